ofifo_deskew: RTL and testbench

- Output-side collector for the systolic array. Each of `col` array columns delivers partial sums with its own valid strobe, and columns are skewed in time because rows are fed in a staggered pattern.
- The block buffers each column in an independent circular queue. It releases a full aligned row (one word from every column) only when every column holds data.
- It is the receiving-end counterpart to the row-staggered input buffering on the array's west side, and feeds the SFU/accumulation stage downstream.

---
 rtl/ofifo_deskew.sv | 75 +++++++
 tb/tb_ofifo_deskew.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_deskew.sv
// rtl/ofifo_deskew.sv - per-column psum queues that release fully aligned rows
// Each column has its own write pointer; one shared read pointer pops a whole row at once.
module ofifo_deskew #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              out_vld,
  output logic              o_valid,
  output logic              o_ready,
  output logic              o_full,
  output logic              o_ovf
);

  localparam int aw = $clog2(depth);

  logic [bw-1:0]  mem  [col][depth];
  logic [aw:0]    wptr [col];
  logic [aw:0]    rptr;
  logic [col-1:0] empty;
  logic [col-1:0] full;
  logic [col-1:0] wr_ok;
  logic           rd_ok;

  // The extra pointer MSB separates full (same address, lap differs) from empty.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < col; i++) begin
      empty[i] = (wptr[i] == rptr);
      full[i]  = (wptr[i][aw-1:0] == rptr[aw-1:0]) && (wptr[i][aw] != rptr[aw]);
    end
  end

  assign o_valid = ~|empty;
  assign o_ready = ~|full;
  assign o_full  = |full;
  assign rd_ok   = rd && o_valid;
  assign wr_ok   = wr & ~full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < col; i++) begin
        if (wr_ok[i]) mem[i][wptr[i][aw-1:0]] <= in[i*bw +: bw];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) wptr[i] <= '0;
      rptr    <= '0;
      out     <= '0;
      out_vld <= 1'b0;
      o_ovf   <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        if (wr_ok[i]) wptr[i] <= wptr[i] + 1'b1;
      end
      if (|(wr & full)) o_ovf <= 1'b1;
      out_vld <= rd_ok;
      if (rd_ok) begin
        rptr <= rptr + 1'b1;
        for (int i = 0; i < col; i++) out[i*bw +: bw] <= mem[i][rptr[aw-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_ofifo_deskew.sv
// tb/tb_ofifo_deskew.sv - self-checking bench for ofifo_deskew
// Reference model of per-column queues feeds an expected-row scoreboard.
module tb_ofifo_deskew;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DEP = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic [COL*BW-1:0] in;
  logic [COL-1:0]    wr;
  logic              rd;
  logic [COL*BW-1:0] out;
  logic              out_vld, o_valid, o_ready, o_full, o_ovf;

  ofifo_deskew #(.col(COL), .bw(BW), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .out_vld(out_vld), .o_valid(o_valid), .o_ready(o_ready),
    .o_full(o_full), .o_ovf(o_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0]     mmem [COL][DEP];
  int                mw [COL];
  int                mr;
  logic              movf;
  logic [COL*BW-1:0] last_out;
  logic [COL*BW-1:0] exp_q [$];
  logic              exp_vld;

  task automatic chk(input string nm, input logic [COL*BW-1:0] act, input logic [COL*BW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < COL; i++) mw[i] = 0;
    mr = 0;
    movf = 1'b0;
    last_out = '0;
    exp_q.delete();
  endtask

  // One clock with the model updated from pre-edge occupancy, then scoreboard checks.
  task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r);
    logic [COL-1:0]    fullv;
    logic              all_ne;
    logic [COL*BW-1:0] row;
    wr = w; in = d; rd = r;
    all_ne = 1'b1;
    for (int i = 0; i < COL; i++) begin
      fullv[i] = ((mw[i] - mr) == DEP);
      if (mw[i] == mr) all_ne = 1'b0;
    end
    exp_vld = r && all_ne;
    if (exp_vld) begin
      for (int i = 0; i < COL; i++) row[i*BW +: BW] = mmem[i][mr % DEP];
      exp_q.push_back(row);
    end
    for (int i = 0; i < COL; i++) begin
      if (w[i]) begin
        if (fullv[i]) movf = 1'b1;
        else begin
          mmem[i][mw[i] % DEP] = d[i*BW +: BW];
          mw[i]++;
        end
      end
    end
    if (exp_vld) mr++;
    @(posedge clk); #1;
    chk("out_vld", out_vld, exp_vld);
    if (out_vld) begin
      if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        row = exp_q.pop_front();
        chk("out_row", out, row);
        last_out = row;
      end
    end else chk("out_hold", out, last_out);
    begin
      logic ev, er, ef;
      ev = 1'b1; er = 1'b1; ef = 1'b0;
      for (int i = 0; i < COL; i++) begin
        if (mw[i] == mr) ev = 1'b0;
        if ((mw[i] - mr) == DEP) begin er = 1'b0; ef = 1'b1; end
      end
      chk("o_valid", o_valid, ev);
      chk("o_ready", o_ready, er);
      chk("o_full", o_full, ef);
      chk("o_ovf", o_ovf, movf);
    end
  endtask

  task automatic do_reset(input int n, input logic [COL-1:0] w, input logic r);
    reset = 1'b1; wr = w; rd = r; in = '1;
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      chk("rst_out", out, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_o_valid", o_valid, 0);
      chk("rst_o_ready", o_ready, 1);
      chk("rst_o_full", o_full, 0);
      chk("rst_o_ovf", o_ovf, 0);
    end
    reset = 1'b0; wr = '0; rd = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic [COL-1:0] w;
    logic           r;
    logic           ev;
    logic           evld;
  } vec_t;

  vec_t              tbl [15];
  int                wc [COL];
  int                k;
  logic [COL*BW-1:0] d;

  initial begin
    tbl[0]  = '{8'h01, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'h03, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{8'h07, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{8'h0F, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h1E, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'h3C, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h78, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'hF0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{8'hE0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{8'hC0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{8'h80, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{8'h00, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{8'h00, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{8'h00, 1'b1, 1'b1, 1'b1};
    tbl[14] = '{8'h00, 1'b1, 1'b0, 1'b1};

    model_clear();
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    do_reset(2, '1, 1'b1);

    // Skewed fill then four row pops.
    for (int i = 0; i < COL; i++) wc[i] = 0;
    k = 0;
    for (int t = 0; t < 15; t++) begin
      for (int i = 0; i < COL; i++) d[i*BW +: BW] = {4'h0, 4'(i), 4'h0, 4'(wc[i])};
      step(tbl[t].w, d, tbl[t].r);
      for (int i = 0; i < COL; i++) if (tbl[t].w[i]) wc[i]++;
      chk("skew_valid", o_valid, tbl[t].ev);
      chk("skew_vld", out_vld, tbl[t].evld);
      if (out_vld) begin
        for (int i = 0; i < COL; i++) d[i*BW +: BW] = {4'h0, 4'(i), 4'h0, 4'(k)};
        chk("skew_row", out, d);
        k++;
      end
    end

    // Fill column 0 to full, overflow, then complete one row.
    do_reset(1, '0, 1'b0);
    for (int n = 0; n < DEP; n++) step(8'h01, {112'h0, 16'hA000 + 16'(n)}, 1'b0);
    chk("full_o_full", o_full, 1);
    chk("full_o_ready", o_ready, 0);
    chk("full_o_valid", o_valid, 0);
    chk("full_o_ovf_pre", o_ovf, 0);
    step(8'h01, {112'h0, 16'hDEAD}, 1'b0);
    chk("ovf_set", o_ovf, 1);
    step(8'h00, '0, 1'b0);
    chk("ovf_sticky", o_ovf, 1);
    step(8'hFE, {COL{16'h1111}}, 1'b0);
    step(8'h00, '0, 1'b1);
    chk("ovf_pop_slice0", out[15:0], 16'hA000);

    // Wrap-around streaming at constant occupancy 3.
    do_reset(1, '0, 1'b0);
    for (int n = 0; n < 203; n++) begin
      for (int i = 0; i < COL; i++) d[i*BW +: BW] = {4'(i), 12'(n)};
      step('1, d, n >= 3);
      if (n >= 3) begin
        for (int i = 0; i < COL; i++) d[i*BW +: BW] = {4'(i), 12'(n - 3)};
        chk("stream_row", out, d);
      end
    end
    chk("stream_no_ovf", o_ovf, 0);

    // Read ignored while column 5 is empty.
    do_reset(1, '0, 1'b0);
    step(8'hDF, {COL{16'h5A01}}, 1'b0);
    step(8'hDF, {COL{16'h5A02}}, 1'b0);
    step(8'h00, '0, 1'b1);
    chk("idle_vld", out_vld, 0);
    chk("idle_out", out, 0);
    step(8'h20, {COL{16'h5B01}}, 1'b0);
    step(8'h20, {COL{16'h5B02}}, 1'b0);
    step(8'h00, '0, 1'b1);
    chk("idle_pop_s0", out[15:0], 16'h5A01);
    chk("idle_pop_s5", out[95:80], 16'h5B01);

    // Reset while rows are buffered and rd is held.
    do_reset(1, '0, 1'b0);
    for (int n = 0; n < 10; n++) step('1, {COL{16'hC000 + 16'(n)}}, 1'b0);
    do_reset(1, '0, 1'b1);
    step('1, {COL{16'hBEEF}}, 1'b0);
    step('0, '0, 1'b1);
    chk("post_rst_row", out, {COL{16'hBEEF}});
    step('0, '0, 1'b1);
    chk("post_rst_empty_vld", out_vld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
